// File: rtl/uart_frame_controller_pkg.sv
// Shared definitions for the UART frame controller: sync byte, abort causes, parser states.
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ERR_OVERRUN  = 2'd0,
        ERR_LENGTH   = 2'd1,
        ERR_CHECKSUM = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        COMMIT  = 3'd5
    } state_e;

endpackage

// File: rtl/uart_frame_controller_if.sv
// Byte-in / register-write-out bundle between the UART receiver, the frame controller and the register sink.
interface uart_frame_controller_if;
    import uart_frame_pkg::*;

    logic       available;
    logic [7:0] data;
    logic [7:0] writeAddress;
    logic [7:0] writeData;
    logic       writeValid;
    logic       writeReady;
    logic       frameDone;
    logic       frameError;
    err_e       errorCode;
    logic       busy;

    modport master (
        input  available, data, writeReady,
        output writeAddress, writeData, writeValid, frameDone, frameError, errorCode, busy
    );

    modport slave (
        output available, data, writeReady,
        input  writeAddress, writeData, writeValid, frameDone, frameError, errorCode, busy
    );

endinterface

// File: rtl/uart_frame_controller_buffer.sv
// Payload buffer: simple dual-port RAM, one write port and one registered read port.
module uart_frame_buffer
    import uart_frame_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_controller.sv
// Parses SYNC/ADDR/LEN/payload/CHK frames from the UART byte strobe and, once the checksum
// matches, replays the buffered payload as auto-incrementing register writes.
module uart_frame_controller
    import uart_frame_pkg::*;
#(
    parameter int unsigned clockRate    = 76_800_000,
    parameter int unsigned uartRate     = 12_000_000,
    parameter int unsigned maxLength    = 16,
    parameter int unsigned timeoutBytes = 4
) (
    input logic                     clk,
    input logic                     reset,
    uart_frame_controller_if.master bus
);

    localparam longint TLIM = (longint'(timeoutBytes) * 64'd10 * longint'(clockRate)) / longint'(uartRate);
    localparam int     TW   = $clog2(TLIM + 1);
    localparam int     AW   = (maxLength > 1) ? $clog2(maxLength) : 1;

    state_e        state_q;
    logic [7:0]    base_q;
    logic [7:0]    len_q;
    logic [7:0]    idx_q;
    logic [7:0]    acc_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    wa_q;
    logic [7:0]    wd_q;
    logic          wv_q;
    logic          done_q;
    logic          err_q;
    logic          ovr_pend_q;
    err_e          code_q;

    logic [7:0]    rd_idx_d;
    logic [7:0]    rdata;
    logic          timed;
    logic          expire;
    logic          accept;
    logic          last;

    assign timed  = (state_q == ADDR) || (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
    assign expire = timed && !bus.available && (tmo_q == TW'(TLIM - 1));
    assign accept = wv_q && bus.writeReady;
    assign last   = (idx_q == len_q - 8'd1);

    // Read address runs one step ahead so the next payload byte is ready when the FSM reloads the write.
    always_comb begin
        rd_idx_d = idx_q;
        if (state_q == CHECK) begin
            rd_idx_d = 8'd0;
        end else if (state_q == COMMIT && accept && !last) begin
            rd_idx_d = idx_q + 8'd1;
        end
    end

    uart_frame_buffer #(
        .DEPTH (int'(maxLength)),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .we_i    (bus.available && (state_q == PAYLOAD)),
        .waddr_i (idx_q[AW-1:0]),
        .wdata_i (bus.data),
        .raddr_i (rd_idx_d[AW-1:0]),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= 8'd0;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            acc_q      <= 8'd0;
            tmo_q      <= '0;
            wa_q       <= 8'd0;
            wd_q       <= 8'd0;
            wv_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovr_pend_q <= 1'b0;
            code_q     <= ERR_OVERRUN;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // An overrun that landed on the final accept is reported one cycle after frameDone.
            if (ovr_pend_q) begin
                err_q      <= 1'b1;
                code_q     <= ERR_OVERRUN;
                ovr_pend_q <= 1'b0;
            end
            tmo_q <= (!timed || bus.available) ? '0 : tmo_q + 1'b1;

            if (expire) begin
                err_q   <= 1'b1;
                code_q  <= ERR_TIMEOUT;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.available && bus.data == SYNC_BYTE) state_q <= ADDR;
                    end
                    ADDR: begin
                        if (bus.available) begin
                            base_q  <= bus.data;
                            acc_q   <= bus.data;
                            state_q <= LEN;
                        end
                    end
                    LEN: begin
                        if (bus.available) begin
                            if (bus.data == 8'd0 || bus.data > 8'(maxLength)) begin
                                err_q   <= 1'b1;
                                code_q  <= ERR_LENGTH;
                                state_q <= IDLE;
                            end else begin
                                len_q   <= bus.data;
                                acc_q   <= acc_q + bus.data;
                                idx_q   <= 8'd0;
                                state_q <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (bus.available) begin
                            acc_q <= acc_q + bus.data;
                            idx_q <= idx_q + 8'd1;
                            if (idx_q + 8'd1 == len_q) state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (bus.available) begin
                            if (bus.data == acc_q) begin
                                idx_q   <= 8'd0;
                                state_q <= COMMIT;
                            end else begin
                                err_q   <= 1'b1;
                                code_q  <= ERR_CHECKSUM;
                                state_q <= IDLE;
                            end
                        end
                    end
                    COMMIT: begin
                        if (bus.available) begin
                            if (accept && last) begin
                                ovr_pend_q <= 1'b1;
                            end else begin
                                err_q  <= 1'b1;
                                code_q <= ERR_OVERRUN;
                            end
                        end
                        if (!wv_q) begin
                            wa_q <= base_q + idx_q;
                            wd_q <= rdata;
                            wv_q <= 1'b1;
                        end else if (bus.writeReady) begin
                            wv_q <= 1'b0;
                            if (last) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                idx_q <= idx_q + 8'd1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.writeAddress = wa_q;
    assign bus.writeData    = wd_q;
    assign bus.writeValid   = wv_q;
    assign bus.frameDone    = done_q;
    assign bus.frameError   = err_q;
    assign bus.errorCode    = code_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_controller.sv
// Randomised and directed frames against a frame-level reference model of the controller.
module tb_uart_frame_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_frame_controller_if bus();

    uart_frame_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;

    logic [15:0] got_wr[$];
    logic [15:0] exp_wr[$];
    int          got_err[$];
    int          exp_err[$];
    int          got_done = 0;
    int          exp_done = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.available = 1'b1;
        bus.data      = b;
        tick();
        bus.available = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int maxgap);
        foreach (q[k]) send_byte(q[k], int'($urandom_range(0, maxgap)));
    endtask

    // Reference: skip to sync, then apply the length/checksum rules to the whole frame at once.
    function automatic void model(input logic [7:0] q[$]);
        int i = 0;
        int addr, len, sum;
        exp_wr.delete();
        exp_err.delete();
        exp_done = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        if (i + 2 >= q.size()) return;
        addr = q[i+1];
        len  = q[i+2];
        if (len == 0 || len > 16) begin
            exp_err.push_back(1);
            return;
        end
        sum = addr + len;
        for (int k = 0; k < len; k++) sum += q[i+3+k];
        if (q[i+3+len] != sum % 256) begin
            exp_err.push_back(2);
            return;
        end
        for (int k = 0; k < len; k++) exp_wr.push_back({8'((addr + k) % 256), q[i+3+k]});
        exp_done = 1;
    endfunction

    task automatic clear_mon();
        got_wr.delete();
        got_err.delete();
        got_done = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 3000) begin
            tick();
            n++;
        end
        check_eq("idle_bound", 32'(n < 3000), 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_frame(input string tag);
        check_eq({tag, "_nwr"}, got_wr.size(), exp_wr.size());
        for (int k = 0; k < got_wr.size() && k < exp_wr.size(); k++)
            check_eq({tag, "_wr"}, got_wr[k], exp_wr[k]);
        check_eq({tag, "_done"}, got_done, exp_done);
        check_eq({tag, "_nerr"}, got_err.size(), exp_err.size());
        for (int k = 0; k < got_err.size() && k < exp_err.size(); k++)
            check_eq({tag, "_code"}, got_err[k], exp_err[k]);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        clear_mon();
    endtask

    // Sink readiness pattern, changed once per cycle just after the edge.
    initial begin
        logic tg = 1'b0;
        bus.writeReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tg = ~tg;
            case (rdy_mode)
                0: bus.writeReady = 1'b1;
                1: bus.writeReady = ($urandom_range(0, 9) < 6);
                2: bus.writeReady = tg;
                default: bus.writeReady = 1'b0;
            endcase
        end
    end

    // Monitor on the falling edge: collects writes and pulses, checks stall stability.
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pa = 8'd0, pd = 8'd0;
    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr)
                check_eq("stall_hold", {bus.writeValid, bus.writeAddress, bus.writeData}, {1'b1, pa, pd});
            if (bus.writeValid && bus.writeReady) got_wr.push_back({bus.writeAddress, bus.writeData});
            if (bus.frameDone) got_done++;
            if (bus.frameError) got_err.push_back(int'(bus.errorCode));
            if (bus.frameDone || bus.frameError)
                check_eq("done_err_excl", 32'(bus.frameDone & bus.frameError), 32'd0);
            pv = bus.writeValid;
            pr = bus.writeReady;
            pa = bus.writeAddress;
            pd = bus.writeData;
        end
    end

    initial begin
        logic [7:0] f[$];
        bus.available = 1'b0;
        bus.data      = 8'd0;
        repeat (3) tick();
        check_eq("rst_wv", bus.writeValid, 1'b0);
        check_eq("rst_done", bus.frameDone, 1'b0);
        check_eq("rst_err", bus.frameError, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_code", bus.errorCode, 2'd0);
        check_eq("rst_wa", bus.writeAddress, 8'd0);
        check_eq("rst_wd", bus.writeData, 8'd0);
        reset = 1'b0;
        tick();
        clear_mon();

        f = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
        send_seq(f, 2);
        wait_idle();
        model(f);
        check_eq("good_plan", exp_wr.size(), 2);
        check_frame("good");

        f = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
        send_seq(f, 1);
        wait_idle();
        model(f);
        check_frame("badchk");

        f = '{8'hA5, 8'h10, 8'h00};
        send_seq(f, 1);
        wait_idle();
        model(f);
        check_frame("len0");
        f = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h11};
        send_seq(f, 1);
        wait_idle();
        model(f);
        check_frame("len17");

        // Timeout: no byte after ADDR.
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        repeat (255) tick();
        check_eq("tmo_early", bus.frameError, 1'b0);
        tick();
        check_eq("tmo_err", bus.frameError, 1'b1);
        check_eq("tmo_code", bus.errorCode, 2'd3);
        check_eq("tmo_busy", bus.busy, 1'b0);
        repeat (3) tick();
        clear_mon();

        // A byte on the expiry cycle keeps the frame alive.
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        repeat (255) tick();
        send_byte(8'h01, 0);
        check_eq("tmo_win_err", bus.frameError, 1'b0);
        check_eq("tmo_win_busy", bus.busy, 1'b1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        wait_idle();
        model('{8'hA5, 8'h10, 8'h01, 8'h33, 8'h44});
        check_frame("tmo_win");

        rdy_mode = 2;
        f = '{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h66};
        send_seq(f, 0);
        wait_idle();
        model(f);
        check_eq("wrap_a0", exp_wr[1], 16'h00BB);
        check_frame("wrap");

        rdy_mode = 3;
        send_seq(f, 0);
        repeat (3) tick();
        send_byte(8'h5A, 2);
        rdy_mode = 2;
        wait_idle();
        model(f);
        exp_err.push_back(0);
        check_frame("overrun");

        // Random frames: good, bad checksum, bad length, with garbage lead-in.
        for (int n = 0; n < 40; n++) begin
            int kind = int'($urandom_range(0, 9));
            int len;
            int sum;
            f.delete();
            rdy_mode = int'($urandom_range(0, 2));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                logic [7:0] gb = 8'($urandom_range(0, 255));
                if (gb == 8'hA5) gb = 8'h00;
                f.push_back(gb);
            end
            f.push_back(8'hA5);
            f.push_back(8'($urandom_range(0, 255)));
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
                f.push_back(8'(len));
            end else begin
                len = int'($urandom_range(1, 16));
                f.push_back(8'(len));
                sum = f[f.size()-2] + len;
                for (int k = 0; k < len; k++) begin
                    f.push_back(8'($urandom_range(0, 255)));
                    sum += f[f.size()-1];
                end
                if (kind == 1) f.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
                else           f.push_back(8'(sum));
            end
            send_seq(f, 3);
            wait_idle();
            model(f);
            check_frame("rand");
        end

        // Reset mid-frame, then a good frame.
        rdy_mode = 0;
        send_seq('{8'hA5, 8'h10, 8'h02, 8'h11}, 0);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_wv", bus.writeValid, 1'b0);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_err", bus.frameError, 1'b0);
        check_eq("mid_rst_done", bus.frameDone, 1'b0);
        check_eq("mid_rst_out", {bus.writeAddress, bus.writeData, 6'd0, bus.errorCode}, 24'd0);
        reset = 1'b0;
        tick();
        f = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
        send_seq(f, 1);
        wait_idle();
        model(f);
        check_frame("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_controller.md
Name: uart_frame_controller

Overview:
Frame-level controller behind the UART receiver. It consumes the receiver's byte strobe (`available`/`data`) and parses command frames: SYNC, ADDR, LEN, payload, CHK. Each frame's payload is buffered and checksum-verified before any write is issued. On a good checksum, the payload is sequenced as register writes, with auto-incrementing addresses, into the FM transmitter configuration space.

Parameters:
clockRate, 76_800_000, system clock frequency in Hz
uartRate, 12_000_000, UART bit rate in Hz
maxLength, 16, maximum payload bytes per frame (1..255)
timeoutBytes, 4, inter-byte idle limit in byte-times (10 bits each) before a frame is aborted

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
available  input  1  one-cycle strobe: received byte valid
data  input  8  received byte, valid when available=1
writeAddress  output  8  register address of current write
writeData  output  8  register data of current write
writeValid  output  1  write request; held until accepted
writeReady  input  1  sink accepts write when writeValid&writeReady
frameDone  output  1  one-cycle pulse after last write of a good frame is accepted
frameError  output  1  one-cycle pulse on frame abort
errorCode  output  2  cause, valid with frameError: 0 overrun, 1 length, 2 checksum, 3 timeout
busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named `clk` and `reset`.
- Reset values: state IDLE; writeValid, frameDone, frameError, busy = 0; errorCode, writeAddress, writeData = 0; timeout counter cleared.
- Reset mid-frame or mid-commit: the frame is abandoned. No further writes and no error pulse are produced.
- Checksum: CHK = (ADDR + LEN + sum of payload) mod 256, using an 8-bit wrapping accumulator.
- Timeout limit T = (timeoutBytes*10*clockRate)/uartRate clocks, computed in integer arithmetic. With the defaults, T = 256.
- Timeout counter:
  - Counts clocks in ADDR, LEN, PAYLOAD and CHECK.
  - Clears on every available strobe.
  - Reaching T aborts the frame with code 3.
  - If available and expiry coincide in the same cycle, the byte wins.
- States and transitions:
  - IDLE: on available with data==0xA5, go to ADDR. Any other byte is discarded silently.
  - ADDR: latch the base address; acc=data; go to LEN.
  - LEN:
    - If data==0 or data>maxLength: frameError, code 1, go to IDLE.
    - Otherwise latch LEN, acc+=data, index=0, go to PAYLOAD.
  - PAYLOAD: store data at buffer[index]; acc+=data; index++. When index reaches LEN, go to CHECK.
  - CHECK:
    - If data==acc: go to COMMIT with index=0.
    - Otherwise: frameError, code 2, go to IDLE.
  - COMMIT:
    - Present writeAddress=base+index (8-bit wrap, so 0xFF+1 = 0x00) and writeData=buffer[index], with writeValid=1.
    - Advance on writeValid&writeReady.
    - After the last accept: writeValid=0, frameDone pulses on the next cycle, go to IDLE.
- Write handshake: writeAddress, writeData and writeValid must not change while writeValid=1 and writeReady=0.
- Overrun: an available strobe during COMMIT is discarded and pulses frameError with code 0. The commit continues unaffected.
- Buffer read latency is 1 cycle. The first writeValid asserts no later than 2 cycles after the CHK byte strobe.
- At most one of frameDone and frameError is high in any cycle.

Decomposition:
- Shared package uart_frame_pkg holds:
  - SYNC_BYTE = 8'hA5
  - error codes ERR_OVERRUN, ERR_LENGTH, ERR_CHECKSUM, ERR_TIMEOUT
  - state encodings IDLE, ADDR, LEN, PAYLOAD, CHECK, COMMIT
- One sub-module, uart_frame_buffer: maxLength x 8 simple dual-port RAM with a synchronous read.

Test Plan:
- Good frame: A5 10 02 11 22 45 with writeReady=1 -> writes (0x10,0x11) then (0x11,0x22); frameDone=1 once; no frameError.
- Bad checksum: A5 10 02 11 22 46 -> frameError with errorCode=2; zero writeValid cycles; busy=0 afterwards.
- Length error: A5 10 00 -> frameError with code 1. Then A5 20 11 ... (LEN 17 > maxLength) -> code 1. Garbage bytes 00 FF before A5 produce no response.
- Timeout: A5 10, then idle -> frameError with code 3 exactly 256 clocks after the 0x10 strobe. A byte arriving on cycle 256 instead continues the frame.
- Address wrap with backpressure: A5 FF 02 AA BB 66, writeReady toggling 0/1 -> writes (0xFF,0xAA), (0x00,0xBB); outputs stable while stalled. A byte injected during COMMIT -> code 0 and both writes still complete.
- Reset mid-frame: assert reset after A5 10 02 11 -> all outputs 0 next cycle. A following good frame (the first scenario) is decoded correctly.
